// File: rtl/panel_tracker_pkg.sv
// Shared types for the panel axis tracker: FSM states, angle type, deviation helper.
package panel_tracker_pkg;

  localparam int ANGLE_W_DFLT = 8;

  typedef logic [ANGLE_W_DFLT-1:0] angle_t;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    SETTLE,
    COMPARE,
    MOVE,
    DONE
  } state_t;

  // Unsigned distance without wrap; callers zero-extend angles up to 32 bits.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/panel_axis_tracker_axis_slew.sv
// One panel axis: angle register plus direct-load or slew-limited approach.
// PANEL_SLEW_LIMIT_EN selects slew limiting (MAX_STEP per cycle); default is direct load.
module axis_slew #(
  parameter int ANGLE_W  = 8,
  parameter int MAX_STEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               enable,
  input  logic [ANGLE_W-1:0] target,
  output logic [ANGLE_W-1:0] angle,
  output logic               at_target
);

  if (MAX_STEP < 1) begin : g_bad_step
    $error("axis_slew: MAX_STEP must be at least 1");
  end

`ifdef PANEL_SLEW_LIMIT_EN
  localparam logic [ANGLE_W-1:0] STEP = ANGLE_W'(MAX_STEP);

  logic [ANGLE_W-1:0] remaining;
  logic [ANGLE_W-1:0] step;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    remaining = (target > angle) ? (target - angle) : (angle - target);
    step      = (remaining > STEP) ? STEP : remaining;
    // at_target means "equals the target once this cycle's step lands".
    at_target = (load && enable) ? (remaining <= STEP) : (remaining == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      angle <= '0;
    end else if (load && enable) begin
      angle <= (target > angle) ? (angle + step) : (angle - step);
    end
  end
`else
  always_comb begin
    at_target = (load && enable) || (angle == target);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      angle <= '0;
    end else if (load && enable) begin
      angle <= target;
    end
  end
`endif

endmodule

// File: rtl/panel_axis_tracker.sv
// Periodic light-search sequencer committing per-axis angles past a hysteresis threshold.
// PANEL_SLEW_LIMIT_EN enables slew-limited movement in the axis_slew instances.
module panel_axis_tracker
  import panel_tracker_pkg::*;
#(
  parameter int NUM_AXES       = 2,
  parameter int ANGLE_W        = 8,
  parameter int THRESHOLD      = 10,
  parameter int PERIOD_CYCLES  = 6000,
  parameter int SETTLE_CYCLES  = 5,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_STEP       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        force_update,
  output logic                        search_req,
  input  logic                        search_done,
  input  logic [NUM_AXES*ANGLE_W-1:0] target_angle,
  output logic [NUM_AXES*ANGLE_W-1:0] panel_angle,
  output logic [NUM_AXES-1:0]         axis_moved,
  output logic                        update_pulse,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);

  state_t                      state;
  logic [PW-1:0]               period_cnt;
  logic [TW-1:0]               timeout_cnt;
  logic [SW-1:0]               settle_cnt;
  logic                        pending;
  logic [NUM_AXES*ANGLE_W-1:0] target_q;
  logic [NUM_AXES-1:0]         move_en;
  logic [NUM_AXES-1:0]         move_en_q;
  logic [NUM_AXES-1:0]         at_target;
  logic                        load;

  assign load = (state == MOVE);

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    logic [31:0] diff;

    assign diff       = abs_diff(32'(target_q[i*ANGLE_W +: ANGLE_W]),
                                 32'(panel_angle[i*ANGLE_W +: ANGLE_W]));
    assign move_en[i] = (diff >= 32'(THRESHOLD)) && (diff != '0);

    axis_slew #(
      .ANGLE_W  (ANGLE_W),
      .MAX_STEP (MAX_STEP)
    ) u_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .enable    (move_en_q[i]),
      .target    (target_q[i*ANGLE_W +: ANGLE_W]),
      .angle     (panel_angle[i*ANGLE_W +: ANGLE_W]),
      .at_target (at_target[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: target_q is a plain register bank, so it is reset along with the FSM.
      state        <= IDLE;
      period_cnt   <= '0;
      timeout_cnt  <= '0;
      settle_cnt   <= '0;
      pending      <= 1'b0;
      target_q     <= '0;
      move_en_q    <= '0;
      axis_moved   <= '0;
      search_req   <= 1'b0;
      update_pulse <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      update_pulse <= 1'b0;
      // Requests arriving mid-cycle collapse into one, served on return to IDLE.
      if (force_update && state != IDLE) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (force_update || pending || period_cnt == PERIOD_LAST) begin
            state       <= SEARCH;
            period_cnt  <= '0;
            timeout_cnt <= '0;
            pending     <= 1'b0;
            search_req  <= 1'b1;
            busy        <= 1'b1;
          end else begin
            period_cnt <= period_cnt + PW'(1);
          end
        end

        SEARCH: begin
          if (search_done) begin
            state       <= SETTLE;
            settle_cnt  <= '0;
            search_req  <= 1'b0;
            timeout_err <= 1'b0;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            state       <= IDLE;
            search_req  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end
        end

        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            target_q <= target_angle;
            state    <= COMPARE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        COMPARE: begin
          axis_moved <= move_en;
          move_en_q  <= move_en;
          if (|move_en) begin
            state <= MOVE;
          end else begin
            state        <= DONE;
            update_pulse <= 1'b1;
          end
        end

        MOVE: begin
          if (&(at_target | ~move_en_q)) begin
            state        <= DONE;
            update_pulse <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          search_req <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_panel_axis_tracker.sv
// Directed bench for panel_axis_tracker; follows PANEL_SLEW_LIMIT_EN for movement timing.
module tb_panel_axis_tracker;
  import panel_tracker_pkg::*;

`ifdef PANEL_SLEW_LIMIT_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        force_update = 1'b0;
  logic        search_done = 1'b0;
  logic [15:0] target_angle = '0;
  logic        search_req;
  logic [15:0] panel_angle;
  logic [1:0]  axis_moved;
  logic        update_pulse;
  logic        busy;
  logic        timeout_err;

  int tests_run = 0;
  int tests_failed = 0;
  int last_steps, last_delta, last_max_delta, last_peak;

  always #5 clk = ~clk;

  panel_axis_tracker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .force_update (force_update),
    .search_req   (search_req),
    .search_done  (search_done),
    .target_angle (target_angle),
    .panel_angle  (panel_angle),
    .axis_moved   (axis_moved),
    .update_pulse (update_pulse),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input int budget, output int lat);
    lat = 0;
    while (!search_req && lat < budget) begin
      tick(1);
      lat++;
    end
  endtask

  // Waits for update_pulse, tracing axis 0 steps; optionally pulses force_update for two cycles.
  task automatic wait_pulse(input int force_at, output int lat);
    int prev, cur, d;
    lat = 0;
    last_steps = 0;
    last_delta = 0;
    last_max_delta = 0;
    prev = int'(panel_angle[7:0]);
    last_peak = prev;
    while (lat < 200) begin
      force_update = (force_at >= 0) && (lat == force_at || lat == force_at + 1);
      tick(1);
      lat++;
      cur = int'(panel_angle[7:0]);
      if (cur != prev) begin
        d = (cur > prev) ? cur - prev : prev - cur;
        last_steps++;
        last_delta = d;
        if (d > last_max_delta) last_max_delta = d;
      end
      if (cur > last_peak) last_peak = cur;
      prev = cur;
      if (update_pulse) break;
    end
    force_update = 1'b0;
  endtask

  // One full tracking cycle; targets/expectations are given as (axis0, axis1).
  task automatic run_vec(input string tag, input int t0, input int t1, input int e0, input int e1,
                         input logic [1:0] emoved, input int lat_direct, input int lat_slew,
                         input bit use_force, input int force_at);
    int rl, lat;
    angle_t a0, a1, x0, x1;
    a0 = angle_t'(t0);
    a1 = angle_t'(t1);
    x0 = angle_t'(e0);
    x1 = angle_t'(e1);
    target_angle = {a1, a0};
    if (use_force) begin
      force_update = 1'b1;
      tick(1);
      force_update = 1'b0;
    end
    wait_req(6100, rl);
    check({tag, "/req_seen"}, 32'(rl < 6100), 32'd1);
    tick(20);
    search_done = 1'b1;
    tick(1);
    search_done = 1'b0;
    check({tag, "/req_drop"}, 32'(search_req), 32'd0);
    wait_pulse(force_at, lat);
    check({tag, "/latency"}, 32'(lat), 32'(SLEW ? lat_slew : lat_direct));
    check({tag, "/panel"}, 32'(panel_angle), 32'({x1, x0}));
    check({tag, "/moved"}, 32'(axis_moved), 32'(emoved));
    check({tag, "/busy_done"}, 32'(busy), 32'd1);
    check({tag, "/tmo_err"}, 32'(timeout_err), 32'd0);
    tick(1);
    check({tag, "/pulse_1cyc"}, 32'(update_pulse), 32'd0);
    check({tag, "/busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hi;
    bit seen;

    rst_n = 1'b0;
    tick(3);
    check("rst/panel", 32'(panel_angle), 32'd0);
    check("rst/moved", 32'(axis_moved), 32'd0);
    check("rst/req", 32'(search_req), 32'd0);
    check("rst/pulse", 32'(update_pulse), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/tmo_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;

    // Three automatic periods; only the first one moves.
    wait_req(6100, lat);
    check("period_latency", 32'(lat), 32'd6000);
    run_vec("p1", 40, 30, 40, 30, 2'b11, 7, 16, 1'b0, -1);
    run_vec("p2", 40, 30, 40, 30, 2'b00, 6, 6, 1'b0, -1);
    run_vec("p3", 40, 30, 40, 30, 2'b00, 6, 6, 1'b0, -1);

    // force_update while the period counter holds 100.
    tick(100);
    check("force_idle/before", 32'(search_req), 32'd0);
    force_update = 1'b1;
    tick(1);
    force_update = 1'b0;
    check("force_idle/after", 32'(search_req), 32'd1);
    // Hysteresis edge: axis0 diff 9 holds, axis1 diff 10 moves.
    run_vec("hyst", 49, 40, 40, 40, 2'b10, 7, 9, 1'b0, -1);

    // Full-scale moves with two force pulses landing in COMPARE/MOVE.
    run_vec("wrap_hi", 255, 0, 255, 0, 2'b11, 7, 60, 1'b1, 5);
    check("pending/idle_gap", 32'(search_req), 32'd0);
    tick(1);
    check("pending/req", 32'(search_req), 32'd1);
    run_vec("pending", 246, 9, 255, 0, 2'b00, 6, 6, 1'b0, -1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (search_req) seen = 1'b1;
    end
    check("pending/collapse", 32'(seen), 32'd0);
    run_vec("wrap_lo", 0, 255, 0, 255, 2'b11, 7, 70, 1'b1, -1);

    // Search engine never answers.
    force_update = 1'b1;
    tick(1);
    force_update = 1'b0;
    hi = 0;
    seen = 1'b0;
    while (search_req && hi < 1100) begin
      tick(1);
      hi++;
      if (update_pulse) seen = 1'b1;
    end
    check("timeout/req_cycles", 32'(hi), 32'd1000);
    check("timeout/err", 32'(timeout_err), 32'd1);
    check("timeout/busy", 32'(busy), 32'd0);
    check("timeout/panel", 32'(panel_angle), 32'({8'd255, 8'd0}));
    check("timeout/no_pulse", 32'(seen), 32'd0);

    // Successful search clears timeout_err; axis0 0 -> 250 traced step by step.
    run_vec("recover", 250, 255, 250, 255, 2'b01, 7, 69, 1'b1, -1);
    check("trace/steps", 32'(last_steps), 32'(SLEW ? 63 : 1));
    check("trace/last_step", 32'(last_delta), 32'(SLEW ? 2 : 250));
    check("trace/max_step", 32'(last_max_delta), 32'(SLEW ? 4 : 250));
    check("trace/peak", 32'(last_peak), 32'd250);

    // Reset while a cycle is in flight (mid-MOVE when slewing, in SETTLE otherwise).
    target_angle = {8'd255, 8'd0};
    force_update = 1'b1;
    tick(1);
    force_update = 1'b0;
    tick(20);
    search_done = 1'b1;
    tick(1);
    search_done = 1'b0;
    tick(SLEW ? 8 : 3);
    check("midrst/busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("midrst/panel", 32'(panel_angle), 32'd0);
    check("midrst/moved", 32'(axis_moved), 32'd0);
    check("midrst/req", 32'(search_req), 32'd0);
    check("midrst/pulse", 32'(update_pulse), 32'd0);
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/tmo_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
